bp_be_stride_prefetch_ctrl: RTL and testbench

Back-end controller on the other side of the loop-inference interface. It trains a single-entry stride detector on committed loads and pulses start/confirm discovery toward bp_be_loop_inference. It then consumes the remaining-iteration count over a v/yumi handshake and issues up to that many strided prefetch addresses to the D$ prefetch port over valid/ready.

---
 rtl/bp_be_pkg.sv | 11 +
 rtl/bp_be_stride_detector.sv | 87 ++++++++
 rtl/bp_be_stride_prefetch_ctrl.sv | 107 ++++++++++
 tb/tb_bp_be_stride_prefetch_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types for the back-end stride prefetch controller
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_train,
    e_wait,
    e_issue
  } bp_be_spf_state_e;

endpackage

// File: rtl/bp_be_stride_detector.sv
// rtl/bp_be_stride_detector.sv - single-entry load stride trainer with confidence and age
module bp_be_stride_detector
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p    = 39,
  parameter int start_thresh_p   = 2,
  parameter int confirm_thresh_p = 4,
  parameter int age_limit_p      = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  bp_be_spf_state_e         state_i,
  input  logic                     load_v_i,
  input  logic [vaddr_width_p-1:0] load_pc_i,
  input  logic [vaddr_width_p-1:0] load_eaddr_i,
  output logic [vaddr_width_p-1:0] pc_o,
  output logic [vaddr_width_p-1:0] last_addr_o,
  output logic [vaddr_width_p-1:0] stride_o,
  output logic                     start_o,
  output logic                     confirm_o,
  output logic                     confirm_hit_o
);

  localparam int conf_w_lp = $clog2(confirm_thresh_p + 1);
  localparam int age_w_lp  = $clog2(age_limit_p + 1);
  localparam logic [conf_w_lp-1:0] start_pre_lp   = conf_w_lp'(start_thresh_p - 1);
  localparam logic [conf_w_lp-1:0] confirm_pre_lp = conf_w_lp'(confirm_thresh_p - 1);
  localparam logic [conf_w_lp-1:0] conf_max_lp    = conf_w_lp'(confirm_thresh_p);
  localparam logic [age_w_lp-1:0]  age_last_lp    = age_w_lp'(age_limit_p - 1);

  logic [vaddr_width_p-1:0] pc_r, last_addr_r, stride_r, delta;
  logic [conf_w_lp-1:0]     conf_r;
  logic [age_w_lp-1:0]      age_r;
  logic                     start_r, confirm_r;
  logic                     pc_match, train_load, stride_hit, replace;

  // Stride is a modular difference, so negative strides compare naturally.
  assign pc_match   = (load_pc_i == pc_r);
  assign delta      = load_eaddr_i - last_addr_r;
  assign train_load = load_v_i && (state_i == e_train);
  assign stride_hit = train_load && pc_match && (delta == stride_r) && (delta != '0);
  assign replace    = load_v_i && ((state_i == e_idle) ||
                                   (train_load && !pc_match && (age_r == age_last_lp)));

  assign confirm_hit_o = stride_hit && (conf_r == confirm_pre_lp);
  assign pc_o          = pc_r;
  assign last_addr_o   = last_addr_r;
  assign stride_o      = stride_r;
  assign start_o       = start_r;
  assign confirm_o     = confirm_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_r        <= '0;
      last_addr_r <= '0;
      stride_r    <= '0;
      conf_r      <= '0;
      age_r       <= '0;
      start_r     <= 1'b0;
      confirm_r   <= 1'b0;
    end else begin
      start_r   <= stride_hit && (conf_r == start_pre_lp);
      confirm_r <= confirm_hit_o;
      if (replace) begin
        pc_r        <= load_pc_i;
        last_addr_r <= load_eaddr_i;
        stride_r    <= '0;
        conf_r      <= '0;
        age_r       <= '0;
      end else if (train_load && pc_match) begin
        last_addr_r <= load_eaddr_i;
        age_r       <= '0;
        if (stride_hit) begin
          if (conf_r != conf_max_lp) conf_r <= conf_r + conf_w_lp'(1);
        end else begin
          stride_r <= delta;
          conf_r   <= '0;
        end
      end else if (train_load) begin
        age_r <= age_r + age_w_lp'(1);
      end else if (load_v_i && (state_i == e_wait) && pc_match) begin
        last_addr_r <= load_eaddr_i;
      end
    end
  end

endmodule

// File: rtl/bp_be_stride_prefetch_ctrl.sv
// rtl/bp_be_stride_prefetch_ctrl.sv - loop discovery handshake and strided D$ prefetch issue
module bp_be_stride_prefetch_ctrl
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p    = 39,
  parameter int output_range_p   = 8,
  parameter int start_thresh_p   = 2,
  parameter int confirm_thresh_p = 4,
  parameter int max_prefetch_p   = 16,
  parameter int age_limit_p      = 8,
  parameter int wait_timeout_p   = 256
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_v_i,
  input  logic [vaddr_width_p-1:0]  load_pc_i,
  input  logic [vaddr_width_p-1:0]  load_eaddr_i,
  output logic                      start_discovery_o,
  output logic                      confirm_discovery_o,
  output logic [vaddr_width_p-1:0]  striding_pc_o,
  input  logic [output_range_p-1:0] remaining_iterations_i,
  input  logic                      v_i,
  output logic                      yumi_o,
  output logic                      prefetch_v_o,
  output logic [vaddr_width_p-1:0]  prefetch_addr_o,
  input  logic                      prefetch_ready_i
);

  localparam int timer_w_lp = $clog2(wait_timeout_p + 1);
  localparam logic [timer_w_lp-1:0]     timeout_last_lp = timer_w_lp'(wait_timeout_p - 1);
  localparam logic [output_range_p-1:0] max_count_lp    = output_range_p'(max_prefetch_p);

  bp_be_spf_state_e          state_r;
  logic [timer_w_lp-1:0]     timer_r;
  logic [output_range_p-1:0] count_r, count_clamped;
  logic [vaddr_width_p-1:0]  addr_r, stride, last_addr;
  logic                      confirm_hit;

  bp_be_stride_detector #(
    .vaddr_width_p    (vaddr_width_p),
    .start_thresh_p   (start_thresh_p),
    .confirm_thresh_p (confirm_thresh_p),
    .age_limit_p      (age_limit_p)
  ) detector (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .state_i       (state_r),
    .load_v_i      (load_v_i),
    .load_pc_i     (load_pc_i),
    .load_eaddr_i  (load_eaddr_i),
    .pc_o          (striding_pc_o),
    .last_addr_o   (last_addr),
    .stride_o      (stride),
    .start_o       (start_discovery_o),
    .confirm_o     (confirm_discovery_o),
    .confirm_hit_o (confirm_hit)
  );

  // Counts arriving outside e_wait are stale and simply drained.
  assign count_clamped   = (remaining_iterations_i > max_count_lp) ? max_count_lp
                                                                   : remaining_iterations_i;
  assign yumi_o          = v_i && (state_r != e_issue);
  assign prefetch_v_o    = (state_r == e_issue);
  assign prefetch_addr_o = addr_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      timer_r <= '0;
      count_r <= '0;
      addr_r  <= '0;
    end else begin
      case (state_r)
        e_idle: if (load_v_i) state_r <= e_train;
        e_train: begin
          if (confirm_hit) begin
            state_r <= e_wait;
            timer_r <= '0;
          end
        end
        e_wait: begin
          timer_r <= timer_r + timer_w_lp'(1);
          if (v_i) begin
            count_r <= count_clamped;
            if (count_clamped == '0) begin
              state_r <= e_idle;
            end else begin
              addr_r  <= last_addr + stride;
              state_r <= e_issue;
            end
          end else if (timer_r == timeout_last_lp) begin
            state_r <= e_idle;
          end
        end
        e_issue: begin
          if (prefetch_ready_i) begin
            addr_r  <= addr_r + stride;
            count_r <= count_r - output_range_p'(1);
            if (count_r == output_range_p'(1)) state_r <= e_idle;
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_be_stride_prefetch_ctrl.sv
// tb/tb_bp_be_stride_prefetch_ctrl.sv - self-checking bench for bp_be_stride_prefetch_ctrl
module tb_bp_be_stride_prefetch_ctrl;

  localparam int W = 39;
  localparam int START_T = 2, CONF_T = 4, MAXPF = 16, AGE_L = 8, TIMEOUT = 256;
  localparam int M_IDLE = 0, M_TRAIN = 1, M_WAIT = 2, M_ISSUE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, load_v, v, prefetch_ready;
  logic [W-1:0] load_pc, load_eaddr, striding_pc, prefetch_addr;
  logic [7:0]   remaining_iterations;
  logic         start_discovery, confirm_discovery, yumi, prefetch_v;

  bp_be_stride_prefetch_ctrl #(.vaddr_width_p(W)) dut (
    .clk_i                  (clk),
    .reset_i                (reset),
    .load_v_i               (load_v),
    .load_pc_i              (load_pc),
    .load_eaddr_i           (load_eaddr),
    .start_discovery_o      (start_discovery),
    .confirm_discovery_o    (confirm_discovery),
    .striding_pc_o          (striding_pc),
    .remaining_iterations_i (remaining_iterations),
    .v_i                    (v),
    .yumi_o                 (yumi),
    .prefetch_v_o           (prefetch_v),
    .prefetch_addr_o        (prefetch_addr),
    .prefetch_ready_i       (prefetch_ready)
  );

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: tracked entry plus the list of prefetches still owed.
  int           m_mode = M_IDLE, m_conf = 0, m_age = 0, m_timer = 0;
  logic [W-1:0] m_pc = '0, m_last = '0, m_stride = '0;
  bit           m_start = 0, m_confirm = 0, m_valid = 0;
  logic [W-1:0] m_pfq[$];
  logic [W-1:0] exp_hs[$];

  function automatic void m_take();
    m_pc = load_pc; m_last = load_eaddr; m_stride = '0; m_conf = 0; m_age = 0;
  endfunction

  task automatic model_step();
    bit           nstart = 0, nconf = 0;
    logic [W-1:0] s, a;
    int           n;
    if (reset) begin
      m_mode = M_IDLE; m_pc = '0; m_last = '0; m_stride = '0;
      m_conf = 0; m_age = 0; m_timer = 0; m_start = 0; m_confirm = 0;
      m_pfq.delete();
      m_valid = 1;
      return;
    end
    case (m_mode)
      M_IDLE: if (load_v) begin m_take(); m_mode = M_TRAIN; end
      M_TRAIN: if (load_v) begin
        if (load_pc == m_pc) begin
          s = load_eaddr - m_last;
          if (s == m_stride && s != 0) begin
            m_conf = (m_conf + 1 > CONF_T) ? CONF_T : m_conf + 1;
            nstart = (m_conf == START_T);
            nconf  = (m_conf == CONF_T);
            if (nconf) begin m_mode = M_WAIT; m_timer = 0; end
          end else begin
            m_stride = s; m_conf = 0;
          end
          m_last = load_eaddr; m_age = 0;
        end else begin
          m_age++;
          if (m_age == AGE_L) m_take();
        end
      end
      M_WAIT: begin
        if (v) begin
          n = (int'(remaining_iterations) > MAXPF) ? MAXPF : int'(remaining_iterations);
          for (int k = 1; k <= n; k++) begin
            a = m_last + m_stride * k;
            m_pfq.push_back(a);
          end
          m_mode = (n == 0) ? M_IDLE : M_ISSUE;
        end else begin
          m_timer++;
          if (m_timer == TIMEOUT) m_mode = M_IDLE;
        end
        if (load_v && load_pc == m_pc) m_last = load_eaddr;
      end
      M_ISSUE: if (prefetch_ready) begin
        void'(m_pfq.pop_front());
        if (m_pfq.size() == 0) m_mode = M_IDLE;
      end
      default: ;
    endcase
    m_start = nstart; m_confirm = nconf;
  endtask

  task automatic sample_and_step();
    @(negedge clk);
    if (m_valid) begin
      check_eq("start", start_discovery, m_start);
      check_eq("confirm", confirm_discovery, m_confirm);
      check_eq("striding_pc", striding_pc, m_pc);
      check_eq("yumi", yumi, v && (m_mode != M_ISSUE));
      check_eq("prefetch_v", prefetch_v, m_mode == M_ISSUE);
      if (m_mode == M_ISSUE) check_eq("prefetch_addr", prefetch_addr, m_pfq[0]);
      if (prefetch_v === 1'b1 && prefetch_ready && exp_hs.size() > 0)
        check_eq("plan_addr", prefetch_addr, exp_hs.pop_front());
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) sample_and_step();
  endtask

  task automatic do_reset();
    reset = 1; load_v = 0; v = 0;
    exp_hs.delete();
    step(2);
    reset = 0;
    check_eq("rst_prefetch_v", prefetch_v, 0);
    check_eq("rst_prefetch_addr", prefetch_addr, 0);
    check_eq("rst_striding_pc", striding_pc, 0);
    check_eq("rst_start", start_discovery, 0);
    check_eq("rst_confirm", confirm_discovery, 0);
  endtask

  task automatic load(input logic [W-1:0] pc, input logic [W-1:0] addr);
    load_v = 1; load_pc = pc; load_eaddr = addr;
    sample_and_step();
    load_v = 0;
  endtask

  task automatic train(input logic [W-1:0] pc, input logic [W-1:0] base, input int stride, input int n);
    for (int i = 0; i < n; i++) load(pc, base + W'(stride * i));
  endtask

  task automatic give_count(input int c);
    v = 1; remaining_iterations = c[7:0];
    sample_and_step();
    v = 0;
  endtask

  task automatic drain(input int max_cycles, input int stall_at);
    for (int c = 0; c < max_cycles && m_mode == M_ISSUE; c++) begin
      prefetch_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
      sample_and_step();
    end
    prefetch_ready = 1;
    check_eq("drain_prefetch_v", prefetch_v, 0);
    check_eq("plan_left", exp_hs.size(), 0);
  endtask

  logic [W-1:0] g_pc, g_addr;
  int           g_stride, burst;

  initial begin
    reset = 1; load_v = 0; v = 0; prefetch_ready = 1;
    load_pc = '0; load_eaddr = '0; remaining_iterations = '0;
    do_reset();

    // Training then five prefetches.
    train('h1000, 'h8000, 'h40, 6);
    exp_hs = '{'h8180, 'h81C0, 'h8200, 'h8240, 'h8280};
    give_count(5);
    drain(40, -1);

    // Count clamp to 16.
    step(2);
    train('h1000, 'h8000, 'h40, 6);
    for (int k = 0; k < 16; k++) exp_hs.push_back(W'('h8180 + 'h40 * k));
    give_count(200);
    check_eq("clamp_last", exp_hs[15], 'h8540);
    drain(60, -1);

    // Backpressure for three cycles.
    step(2);
    train('h1000, 'h8000, 'h40, 6);
    exp_hs = '{'h8180, 'h81C0, 'h8200, 'h8240};
    give_count(4);
    drain(40, 1);

    // Stride break then retrain.
    step(2);
    train('h1000, 'h8000, 'h40, 5);
    load('h1000, 'h8100);
    train('h1000, 'h8140, 'h40, 6);
    give_count(0);
    step(3);

    // Timeout, stale count, then a count just inside the window.
    train('h1000, 'h8000, 'h40, 6);
    step(300);
    give_count(5);
    step(3);
    check_eq("stale_prefetch_v", prefetch_v, 0);
    train('h1000, 'h8000, 'h40, 6);
    step(250);
    exp_hs = '{'h8180, 'h81C0};
    give_count(2);
    drain(20, -1);

    // Negative stride, reset mid-issue.
    step(2);
    train('h2000, 'h9000, -8, 6);
    exp_hs = '{'h8FD0, 'h8FC8, 'h8FC0};
    give_count(10);
    prefetch_ready = 1;
    step(3);
    check_eq("neg_plan_left", exp_hs.size(), 0);
    reset = 1;
    sample_and_step();
    check_eq("midissue_prefetch_v", prefetch_v, 0);
    check_eq("midissue_prefetch_addr", prefetch_addr, 0);
    reset = 0;
    step(2);

    // Randomized traffic against the model.
    g_pc = 'h3000; g_addr = 'h10000; g_stride = 16; burst = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        g_pc = W'($urandom_range(1, 4)) << 12;
        g_stride = ($urandom_range(0, 1) != 0 ? 1 : -1) * 8 * int'($urandom_range(0, 8));
      end
      if (burst == 0 && $urandom_range(0, 299) == 0) burst = AGE_L + 1;
      load_v = ($urandom_range(0, 2) != 0);
      if (burst > 0) begin
        load_v = 1; load_pc = 'hF000 + W'($urandom_range(0, 3));
        load_eaddr = W'($urandom); burst--;
      end else if ($urandom_range(0, 3) == 0) begin
        load_pc = 'h7000; load_eaddr = W'($urandom);
      end else begin
        if (load_v) g_addr = g_addr + W'(g_stride);
        if ($urandom_range(0, 39) == 0) g_addr = g_addr + W'($urandom_range(1, 255));
        load_pc = g_pc; load_eaddr = g_addr;
      end
      v = ($urandom_range(0, 9) == 0);
      remaining_iterations = 8'($urandom_range(0, 40));
      prefetch_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 1999) == 0);
      sample_and_step();
    end
    reset = 0; load_v = 0; v = 0; prefetch_ready = 1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
